pcpi_issue_unit: RTL and testbench
==================================

// Module: pcpi_issue_unit
// PURPOSE
// - EX-stage issue/collect unit for the PCPI M-extension coprocessor: detects RV32M ops in EX,
//   registers and holds insn/rs1/rs2, drives pcpi_valid, stalls the pipeline, returns the result.
// - Tolerates ready without busy (div-by-zero, |rs1|<|rs2|, overflow finish with no busy cycle).
// - Flags illegal instruction on timeout (no coprocessor response).
// PARAMETERS
// - TIMEOUT_CYCLES  64  cycles in WAIT without pcpi_ready before trap (must exceed 40)
// - CNT_W  $clog2(TIMEOUT_CYCLES+1)  timeout counter width
// PORTS
// - clk  in  1  clock, rising edge
// - resetn  in  1  reset, asynchronous, active-high
// - ex_valid  in  1  EX stage holds a valid instruction
// - ex_instr  in  32  EX instruction word
// - ex_rs1, ex_rs2  in  32  forwarded operands
// - ex_rd  in  5  destination register
// - flush  in  1  kill the instruction in EX (branch/trap)
// - stall_out  out  1  hold IF/ID/EX
// - wb_valid  out  1  result valid this cycle, write wb_rd
// - wb_rd  out  5  destination register
// - wb_data  out  32  result
// - illegal_instr  out  1  one-cycle pulse, M-op got no response
// - pcpi_valid  out  1  request to coprocessor
// - pcpi_insn  out  32  registered instruction
// - pcpi_rs1, pcpi_rs2  out  32  registered operands
// - pcpi_ready  in  1  result available (1-cycle pulse)
// - pcpi_wr  in  1  result must be written
// - pcpi_rd  in  32  result
// - pcpi_busy  in  1  coprocessor busy (monitor only)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; operand, rd and result registers 0; counter 0.
// - is_m = opcode==OPCODE && func7==FUNC7 (ex_instr).
// - IDLE: if ex_valid && is_m && !flush -> register insn/rs1/rs2/rd, clear counter, go WAIT.
//   stall_out=1 combinationally that same cycle. Otherwise stall_out=0.
// - WAIT: pcpi_valid=1, stall_out=1, pcpi_insn/rs1/rs2 held stable (coprocessor samples rs1/rs2
//   again in its DONE cycle). Counter increments each cycle.
//   pcpi_ready -> register pcpi_rd and pcpi_wr, go RESP.
//   flush (without ready) -> DRAIN. Same-cycle flush and ready: ready wins; result discarded, go IDLE.
//   counter==TIMEOUT_CYCLES-1 without ready -> TRAP.
// - RESP: one cycle. pcpi_valid=0 (prevents re-issue). stall_out=0, so EX advances.
//   wb_valid = stored pcpi_wr. wb_data/wb_rd from registers.
//   ex_instr is ignored this cycle (still the completed op). Next state is IDLE.
// - DRAIN: the coprocessor cannot abort. pcpi_valid=1 with held operands and stall_out=0.
//   On pcpi_ready -> IDLE, no wb_valid. A new M-op in EX while in DRAIN is held:
//   stall_out=1 if ex_valid && is_m. On timeout -> IDLE silently.
// - TRAP: illegal_instr=1 for one cycle, pcpi_valid=0, stall_out=0, then IDLE.
// - pcpi_busy never gates progress. An assertion checks pcpi_busy is low in IDLE/RESP/TRAP.
// - Latency (issue cycle = 0, first pcpi_valid = 1):
//   MUL family ready at cycle 5; DIV/REM normal at 35; div-by-zero at 2; wb_valid one cycle after ready.
// - Back-to-back M-ops: earliest reissue is the cycle after RESP. Minimum spacing 2 cycles.
// - Reset mid-operation: return to IDLE immediately, with no wb_valid or illegal pulse.
// STRUCTURE
// - Shared package m_definitions gains:
//   typedef enum logic [2:0] {PI_IDLE, PI_WAIT, PI_RESP, PI_DRAIN, PI_TRAP} pcpi_issue_state_t.
// - Reuse existing OPCODE, FUNC7, get_ir_opcode and get_ir_func7 helpers; no local copies.
// - No sub-module. Single FSM plus operand/result registers plus timeout counter.
// TESTING
// - MUL x5=7*-3, ex_rd=5 -> pcpi_valid cycles 1..5; wb_valid@6, wb_data=32'hFFFFFFEB, wb_rd=5;
//   stall_out high cycles 0..5.
// - DIVU 100/7 -> ready ~cycle 35; wb_data=14; pcpi_rs1/rs2 stable for the whole WAIT.
// - DIV 5/0 (ready at cycle 2, busy never high) -> wb_data=32'hFFFFFFFF; no timeout.
// - flush at cycle 10 of a DIV -> stall_out drops, pcpi_valid held until ready, no wb_valid.
//   Following MULHU issues only after the drain completes.
// - Model never asserts ready -> illegal_instr pulse after 64 WAIT cycles; pcpi_valid low next cycle.
// - Reset asserted mid-WAIT -> all outputs 0 asynchronously. Post-reset MUL 3*4 completes with wb_data=12.

Source files
------------

// File: rtl/m_definitions.sv
// m_definitions: shared RV32M encodings, instruction-field helpers and the PCPI issue FSM state type
package m_definitions;
  localparam logic [6:0] OPCODE = 7'b0110011;
  localparam logic [6:0] FUNC7  = 7'b0000001;
  typedef enum logic [2:0] {PI_IDLE, PI_WAIT, PI_RESP, PI_DRAIN, PI_TRAP} pcpi_issue_state_t;
  function automatic logic [6:0] get_ir_opcode(input logic [31:0] ir);
    return ir[6:0];
  endfunction
  function automatic logic [6:0] get_ir_func7(input logic [31:0] ir);
    return ir[31:25];
  endfunction
endpackage

// File: rtl/pcpi_issue_unit_if.sv
// pcpi_issue_unit_if: PCPI request/response bundle between the issue unit and the M coprocessor
interface pcpi_issue_unit_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  modport master (output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
                  input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy);
  modport slave  (input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
                  output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy);
endinterface

// File: rtl/pcpi_issue_unit.sv
// pcpi_issue_unit: EX-stage issue/collect of RV32M ops to the PCPI coprocessor with drain and timeout trap
module pcpi_issue_unit
  import m_definitions::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ex_valid,
  input  logic [31:0]             ex_instr,
  input  logic [31:0]             ex_rs1,
  input  logic [31:0]             ex_rs2,
  input  logic [4:0]              ex_rd,
  input  logic                    flush,
  output logic                    stall_out,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    illegal_instr,
  pcpi_issue_unit_if.master       pcpi
);
  pcpi_issue_state_t state;
  logic [CNT_W-1:0] cnt;
  logic is_m, issue, timeout;
  assign is_m    = get_ir_opcode(ex_instr) == OPCODE && get_ir_func7(ex_instr) == FUNC7;
  assign issue   = ex_valid && is_m && !flush;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // a new M-op arriving during DRAIN is held in EX until the abandoned op retires
  always_comb stall_out = !resetn && (state == PI_WAIT ? 1'b1 :
                                      state == PI_IDLE ? issue :
                                      state == PI_DRAIN ? ex_valid && is_m : 1'b0);
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state           <= PI_IDLE;
      cnt             <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      illegal_instr   <= 1'b0;
      pcpi.pcpi_valid <= 1'b0;
      pcpi.pcpi_insn  <= '0;
      pcpi.pcpi_rs1   <= '0;
      pcpi.pcpi_rs2   <= '0;
    end else begin
      wb_valid      <= 1'b0;
      illegal_instr <= 1'b0;
      case (state)
        PI_IDLE: if (issue) begin
          state           <= PI_WAIT;
          cnt             <= '0;
          pcpi.pcpi_valid <= 1'b1;
          pcpi.pcpi_insn  <= ex_instr;
          pcpi.pcpi_rs1   <= ex_rs1;
          pcpi.pcpi_rs2   <= ex_rs2;
          wb_rd           <= ex_rd;
        end
        PI_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (pcpi.pcpi_ready) begin
            state           <= flush ? PI_IDLE : PI_RESP;
            pcpi.pcpi_valid <= 1'b0;
            wb_data         <= pcpi.pcpi_rd;
            wb_valid        <= !flush && pcpi.pcpi_wr;
          end else if (flush) begin
            state <= PI_DRAIN;
          end else if (timeout) begin
            state           <= PI_TRAP;
            pcpi.pcpi_valid <= 1'b0;
            illegal_instr   <= 1'b1;
          end
        end
        PI_DRAIN: begin
          cnt <= cnt + CNT_W'(1);
          if (pcpi.pcpi_ready || timeout) begin
            state           <= PI_IDLE;
            pcpi.pcpi_valid <= 1'b0;
          end
        end
        default: state <= PI_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!resetn)
      assert (!(pcpi.pcpi_busy && (state == PI_IDLE || state == PI_RESP || state == PI_TRAP)));
endmodule

// File: tb/tb_pcpi_issue_unit.sv
// tb_pcpi_issue_unit: coprocessor model plus per-scenario tasks; writebacks checked against a scoreboard
module tb_pcpi_issue_unit;
  logic clk = 1'b0, resetn = 1'b1, ex_valid = 1'b0, flush = 1'b0;
  logic [31:0] ex_instr = '0, ex_rs1 = '0, ex_rs2 = '0;
  logic [4:0] ex_rd = '0;
  logic stall_out, wb_valid, illegal_instr;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int errors = 0, checks = 0, ill_cnt = 0;
  logic never_ready = 1'b0;
  logic [36:0] exp_q[$];

  pcpi_issue_unit_if pcpi();
  pcpi_issue_unit dut (.clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush), .stall_out(stall_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal_instr(illegal_instr), .pcpi(pcpi));

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] f);
    return {7'b0000001, 5'd2, 5'd1, f, 5'd0, 7'b0110011};
  endfunction

  function automatic logic [31:0] cp_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub;
    logic ovf;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; ua = {32'd0, a}; ub = {32'd0, b};
    ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (f)
      3'd0: return 32'(sa * sb);
      3'd1: return 32'((sa * sb) >> 32);
      3'd2: return 32'((sa * ub) >> 32);
      3'd3: return 32'((ua * ub) >> 32);
      3'd4: return b == 0 ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  // coprocessor: MUL ready after 5 valid cycles, DIV/REM after 35, divide-by-zero after 2 with no busy
  initial begin
    int k, lat;
    logic [31:0] ci, c1, c2;
    k = 0; ci = '0; c1 = '0; c2 = '0;
    pcpi.pcpi_ready = 1'b0; pcpi.pcpi_wr = 1'b0; pcpi.pcpi_rd = '0; pcpi.pcpi_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pcpi.pcpi_valid) begin
        if (k == 0) begin
          ci = pcpi.pcpi_insn; c1 = pcpi.pcpi_rs1; c2 = pcpi.pcpi_rs2;
        end else begin
          checks++;
          if ({pcpi.pcpi_insn, pcpi.pcpi_rs1, pcpi.pcpi_rs2} !== {ci, c1, c2}) begin
            errors++;
            $display("FAIL operand_hold: got %h %h %h expected %h %h %h",
                     pcpi.pcpi_insn, pcpi.pcpi_rs1, pcpi.pcpi_rs2, ci, c1, c2);
          end
        end
        k++;
      end else k = 0;
      lat = ci[14] ? (c2 == 0 ? 2 : 35) : 5;
      pcpi.pcpi_ready = pcpi.pcpi_valid && !never_ready && k == lat;
      pcpi.pcpi_busy  = pcpi.pcpi_valid && (never_ready || k < lat) && !(ci[14] && c2 == 0);
      pcpi.pcpi_wr    = pcpi.pcpi_ready;
      pcpi.pcpi_rd    = pcpi.pcpi_ready ? cp_calc(ci[14:12], c1, c2) : 32'd0;
    end
  end

  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (illegal_instr) ill_cnt++;
      if (wb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          if ({wb_rd, wb_data} !== e) begin
            errors++;
            $display("FAIL wb_result: got rd=%0d data=%h expected rd=%0d data=%h", wb_rd, wb_data, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int maxc, output int endc, output logic [127:0] sh, output logic [127:0] vh,
                        output logic [127:0] wh, output logic [127:0] ih);
    sh = '0; vh = '0; wh = '0; ih = '0; endc = -1;
    ex_valid = 1'b1; ex_instr = mk(f); ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    for (int c = 0; c < maxc && endc < 0; c++) begin
      @(negedge clk);
      sh[c] = stall_out; vh[c] = pcpi.pcpi_valid; wh[c] = wb_valid; ih[c] = illegal_instr;
      if (!stall_out) endc = c;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall_out, wb_valid, illegal_instr, wb_rd, wb_data, pcpi.pcpi_valid, pcpi.pcpi_insn, pcpi.pcpi_rs1, pcpi.pcpi_rs2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b wbv=%b ill=%b pv=%b expected all zero", stall_out, wb_valid, illegal_instr, pcpi.pcpi_valid);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_out, wb_valid, illegal_instr, pcpi.pcpi_valid} !== 4'b0) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected 0000", {stall_out, wb_valid, illegal_instr, pcpi.pcpi_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int endc;
    logic [127:0] sh, vh, wh, ih;
    exp_q.push_back({5'd5, 32'hFFFFFFEB});
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 20, endc, sh, vh, wh, ih);
    ex_valid = 1'b0;
    checks++; if (endc !== 6) begin errors++; $display("FAIL mul_end: got %0d expected 6", endc); end
    checks++; if (sh[7:0] !== 8'h3F) begin errors++; $display("FAIL mul_stall: got %b expected 00111111", sh[7:0]); end
    checks++; if (vh[7:0] !== 8'h3E) begin errors++; $display("FAIL mul_valid: got %b expected 00111110", vh[7:0]); end
    checks++; if (wh[7:0] !== 8'h40) begin errors++; $display("FAIL mul_wbv: got %b expected 01000000", wh[7:0]); end
  endtask

  task automatic test_divu;
    int endc;
    logic [127:0] sh, vh, wh, ih;
    exp_q.push_back({5'd9, 32'd14});
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 60, endc, sh, vh, wh, ih);
    ex_valid = 1'b0;
    checks++; if (endc !== 36) begin errors++; $display("FAIL divu_end: got %0d expected 36", endc); end
    checks++; if (vh[36:0] !== {1'b0, {35{1'b1}}, 1'b0}) begin errors++; $display("FAIL divu_valid: got %h", vh[36:0]); end
    checks++; if (wh[36:0] !== (37'd1 << 36)) begin errors++; $display("FAIL divu_wbv: got %h expected %h", wh[36:0], 37'd1 << 36); end
  endtask

  task automatic test_div_zero;
    int endc, i0;
    logic [127:0] sh, vh, wh, ih;
    i0 = ill_cnt;
    exp_q.push_back({5'd3, 32'hFFFFFFFF});
    run_op(3'd4, 32'd5, 32'd0, 5'd3, 20, endc, sh, vh, wh, ih);
    ex_valid = 1'b0;
    checks++; if (endc !== 3) begin errors++; $display("FAIL div0_end: got %0d expected 3", endc); end
    checks++; if (vh[3:0] !== 4'b0110) begin errors++; $display("FAIL div0_valid: got %b expected 0110", vh[3:0]); end
    checks++; if (ill_cnt !== i0) begin errors++; $display("FAIL div0_illegal: got %0d pulses expected 0", ill_cnt - i0); end
  endtask

  task automatic test_flush_drain;
    logic [45:0] sh, vh, wh, ev, es;
    logic [31:0] ins37;
    sh = '0; vh = '0; wh = '0; ins37 = '0;
    exp_q.push_back({5'd12, 32'd2});
    for (int c = 0; c < 46; c++) begin
      if (c == 0) begin ex_valid = 1'b1; ex_instr = mk(3'd5); ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd4; end
      flush = c == 10;
      if (c == 11) ex_valid = 1'b0;
      if (c == 12) begin ex_valid = 1'b1; ex_instr = mk(3'd3); ex_rs1 = 32'h80000000; ex_rs2 = 32'd4; ex_rd = 5'd12; end
      if (c == 43) ex_valid = 1'b0;
      @(negedge clk);
      sh[c] = stall_out; vh[c] = pcpi.pcpi_valid; wh[c] = wb_valid;
      if (c == 37) ins37 = pcpi.pcpi_insn;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 46; i++) begin
      ev[i] = (i >= 1 && i <= 35) || (i >= 37 && i <= 41);
      es[i] = i <= 10 || (i >= 12 && i <= 41);
    end
    checks++; if (vh !== ev) begin errors++; $display("FAIL drain_valid: got %h expected %h", vh, ev); end
    checks++; if (sh !== es) begin errors++; $display("FAIL drain_stall: got %h expected %h", sh, es); end
    checks++; if (wh !== (46'd1 << 42)) begin errors++; $display("FAIL drain_wbv: got %h expected %h", wh, 46'd1 << 42); end
    checks++; if (ins37 !== mk(3'd3)) begin errors++; $display("FAIL drain_reissue: got %h expected %h", ins37, mk(3'd3)); end
  endtask

  task automatic test_timeout;
    int endc, i0;
    logic [127:0] sh, vh, wh, ih;
    i0 = ill_cnt;
    never_ready = 1'b1;
    run_op(3'd0, 32'd1, 32'd1, 5'd1, 80, endc, sh, vh, wh, ih);
    ex_valid = 1'b0;
    never_ready = 1'b0;
    checks++; if (endc !== 65) begin errors++; $display("FAIL to_end: got %0d expected 65", endc); end
    checks++; if (ih[65:0] !== (66'd1 << 65)) begin errors++; $display("FAIL to_illegal: got %h expected %h", ih[65:0], 66'd1 << 65); end
    checks++; if (vh[65:0] !== {1'b0, {64{1'b1}}, 1'b0}) begin errors++; $display("FAIL to_valid: got %h", vh[65:0]); end
    checks++; if (ill_cnt - i0 !== 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", ill_cnt - i0); end
  endtask

  task automatic test_back_to_back;
    int e1, e2;
    logic [127:0] sh, vh, wh, ih;
    exp_q.push_back({5'd1, 32'd42});
    exp_q.push_back({5'd2, 32'hFFFFFFFF});
    run_op(3'd0, 32'd6, 32'd7, 5'd1, 20, e1, sh, vh, wh, ih);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 5'd2, 20, e2, sh, vh, wh, ih);
    ex_valid = 1'b0;
    checks++; if (e1 !== 6) begin errors++; $display("FAIL b2b_first: got %0d expected 6", e1); end
    checks++; if (e2 !== 6) begin errors++; $display("FAIL b2b_second: got %0d expected 6", e2); end
    checks++; if (vh[1:0] !== 2'b10) begin errors++; $display("FAIL b2b_valid: got %b expected 10", vh[1:0]); end
  endtask

  task automatic test_reset_mid;
    int endc, i0;
    logic [127:0] sh, vh, wh, ih;
    ex_valid = 1'b1; ex_instr = mk(3'd5); ex_rs1 = 32'd1000; ex_rs2 = 32'd3; ex_rd = 5'd6;
    repeat (8) @(posedge clk);
    #3;
    resetn = 1'b1;
    #1;
    checks++;
    if ({stall_out, wb_valid, illegal_instr, wb_rd, wb_data, pcpi.pcpi_valid, pcpi.pcpi_insn, pcpi.pcpi_rs1, pcpi.pcpi_rs2} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got stall=%b pv=%b insn=%h expected all zero", stall_out, pcpi.pcpi_valid, pcpi.pcpi_insn);
    end
    ex_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    i0 = ill_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ill_cnt !== i0) begin errors++; $display("FAIL midreset_illegal: got %0d pulses expected 0", ill_cnt - i0); end
    exp_q.push_back({5'd7, 32'd12});
    run_op(3'd0, 32'd3, 32'd4, 5'd7, 20, endc, sh, vh, wh, ih);
    ex_valid = 1'b0;
    checks++; if (endc !== 6) begin errors++; $display("FAIL postreset_end: got %0d expected 6", endc); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divu();
    test_div_zero();
    test_flush_drain();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
